// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-training bundle between the pipeline and branch_predictor.
// BP_STATS_EN adds the StatBranches/StatMispredicts counter outputs.
interface branch_predictor_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [WIDTH-1:0] PCF;
  logic             PredTakenF;
  logic [WIDTH-1:0] PredTargetF;
  logic             UpdateE;
  logic [WIDTH-1:0] UpdatePCE;
  logic             UpdateTakenE;
  logic [WIDTH-1:0] UpdateTargetE;
  logic             UpdateUncondE;
  logic             PredTakenE;
  logic [WIDTH-1:0] PredTargetE;
  logic             MispredictE;
  logic [WIDTH-1:0] RecoverPCE;
`ifdef BP_STATS_EN
  logic [31:0]      StatBranches;
  logic [31:0]      StatMispredicts;
`endif

  modport master (
    output stall, PCF, UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
           UpdateUncondE, PredTakenE, PredTargetE,
`ifdef BP_STATS_EN
    input  StatBranches, StatMispredicts,
`endif
    input  PredTakenF, PredTargetF, MispredictE, RecoverPCE
  );

  modport slave (
    input  stall, PCF, UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
           UpdateUncondE, PredTakenE, PredTargetE,
`ifdef BP_STATS_EN
    output StatBranches, StatMispredicts,
`endif
    output PredTakenF, PredTargetF, MispredictE, RecoverPCE
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, execute-stage mispredict/recovery.
// Optional BP_STATS_EN adds saturating branch and mispredict counters.
module branch_predictor #(
  parameter int         WIDTH     = 32,
  parameter int         ENTRIES   = 64,
  parameter int         TAG_WIDTH = 10,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_LSB    = INDEX_BITS + 2;

  logic                 validArr  [ENTRIES];
  logic [TAG_WIDTH-1:0] tagArr    [ENTRIES];
  logic [WIDTH-1:0]     targetArr [ENTRIES];
  logic [1:0]           ctrArr    [ENTRIES];

  logic [INDEX_BITS-1:0] idxF, idxE;
  logic [TAG_WIDTH-1:0]  tagF, tagE;
  logic                  hitF, hitE, accept;
  logic [1:0]            ctrE;

  assign idxF = bp.PCF[TAG_LSB-1:2];
  assign tagF = bp.PCF[TAG_LSB +: TAG_WIDTH];
  assign idxE = bp.UpdatePCE[TAG_LSB-1:2];
  assign tagE = bp.UpdatePCE[TAG_LSB +: TAG_WIDTH];

  logic unusedPcBits;
  assign unusedPcBits = ^{bp.PCF[1:0], bp.PCF[WIDTH-1:TAG_LSB+TAG_WIDTH],
                          bp.UpdatePCE[1:0], bp.UpdatePCE[WIDTH-1:TAG_LSB+TAG_WIDTH]};

  assign hitF   = validArr[idxF] && (tagArr[idxF] == tagF);
  assign hitE   = validArr[idxE] && (tagArr[idxE] == tagE);
  assign ctrE   = ctrArr[idxE];
  assign accept = bp.UpdateE && !bp.stall;

  // Lookup reads pre-edge contents; a same-cycle update is not bypassed.
  always_comb begin
    bp.PredTakenF  = hitF && ctrArr[idxF][1];
    bp.PredTargetF = bp.PredTakenF ? targetArr[idxF] : bp.PCF + WIDTH'(4);
  end

  always_comb begin
    bp.MispredictE = bp.UpdateE &&
                     ((bp.PredTakenE != bp.UpdateTakenE) ||
                      (bp.UpdateTakenE && (bp.PredTargetE != bp.UpdateTargetE)));
    bp.RecoverPCE  = bp.UpdateTakenE ? bp.UpdateTargetE : bp.UpdatePCE + WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validArr[i]  <= 1'b0;
        tagArr[i]    <= '0;
        targetArr[i] <= '0;
        ctrArr[i]    <= CTR_INIT;
      end
    end else if (accept) begin
      if (hitE) begin
        if (bp.UpdateUncondE)
          ctrArr[idxE] <= 2'b11;
        else if (bp.UpdateTakenE)
          ctrArr[idxE] <= (ctrE == 2'b11) ? ctrE : ctrE + 2'd1;
        else
          ctrArr[idxE] <= (ctrE == 2'b00) ? ctrE : ctrE - 2'd1;
        if (bp.UpdateTakenE)
          targetArr[idxE] <= bp.UpdateTargetE;
      end else if (bp.UpdateTakenE) begin
        validArr[idxE]  <= 1'b1;
        tagArr[idxE]    <= tagE;
        targetArr[idxE] <= bp.UpdateTargetE;
        ctrArr[idxE]    <= bp.UpdateUncondE ? 2'b11 : 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp.StatBranches    <= '0;
      bp.StatMispredicts <= '0;
    end else if (accept) begin
      if (bp.StatBranches != '1)
        bp.StatBranches <= bp.StatBranches + 32'd1;
      if (bp.MispredictE && (bp.StatMispredicts != '1))
        bp.StatMispredicts <= bp.StatMispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (64 entries, 10-bit tags, CTR_INIT=01).
// Extra counter checks are compiled in when BP_STATS_EN is defined.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(32)) bpIf();

  branch_predictor #(
    .WIDTH(32), .ENTRIES(64), .TAG_WIDTH(10), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp(bpIf)
  );

  int asrtCnt = 0;
  int failCnt = 0;
`ifdef BP_STATS_EN
  logic [31:0] statBase;
`endif

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asrtCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic expTaken,
                        input logic [31:0] expTarget, input string tag);
    @(negedge clk);
    bpIf.PCF = pc;
    #1;
    checkVal({tag, ".taken"},  {31'd0, bpIf.PredTakenF}, {31'd0, expTaken});
    checkVal({tag, ".target"}, bpIf.PredTargetF, expTarget);
  endtask

  task automatic setUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                           input logic uncond, input logic predTaken, input logic [31:0] predTarget);
    bpIf.UpdatePCE     = pc;
    bpIf.UpdateTakenE  = taken;
    bpIf.UpdateTargetE = target;
    bpIf.UpdateUncondE = uncond;
    bpIf.PredTakenE    = predTaken;
    bpIf.PredTargetE   = predTarget;
    bpIf.UpdateE       = 1'b1;
  endtask

  // One accepted training edge; optionally checks the execute-stage outputs first.
  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                       input logic uncond, input logic predTaken, input logic [31:0] predTarget,
                       input bit chk, input logic expMis, input logic [31:0] expRec, input string tag);
    @(negedge clk);
    setUpdate(pc, taken, target, uncond, predTaken, predTarget);
    #1;
    if (chk) begin
      checkVal({tag, ".mis"}, {31'd0, bpIf.MispredictE}, {31'd0, expMis});
      checkVal({tag, ".rec"}, bpIf.RecoverPCE, expRec);
    end
    @(posedge clk);
    #1;
    bpIf.UpdateE = 1'b0;
  endtask

  initial begin
    rst                = 1'b0;
    bpIf.stall         = 1'b0;
    bpIf.PCF           = 32'h100;
    bpIf.UpdateE       = 1'b0;
    bpIf.UpdatePCE     = '0;
    bpIf.UpdateTakenE  = 1'b0;
    bpIf.UpdateTargetE = '0;
    bpIf.UpdateUncondE = 1'b0;
    bpIf.PredTakenE    = 1'b0;
    bpIf.PredTargetE   = '0;
    #1;
    checkVal("rst.taken",  {31'd0, bpIf.PredTakenF}, 32'd0);
    checkVal("rst.target", bpIf.PredTargetF, 32'h104);

    // Update held during reset: execute outputs follow inputs, no training happens.
    setUpdate(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    #1;
    checkVal("rstUpd.mis", {31'd0, bpIf.MispredictE}, 32'd1);
    checkVal("rstUpd.rec", bpIf.RecoverPCE, 32'h80);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bpIf.UpdateE = 1'b0;
    rst = 1'b1;
    lookup(32'h100, 1'b0, 32'h104, "postRst");
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap");

    // First allocation; same-cycle lookup must still see the old (miss) state.
    @(negedge clk);
    bpIf.PCF = 32'h100;
    setUpdate(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    #1;
    checkVal("alloc.mis", {31'd0, bpIf.MispredictE}, 32'd1);
    checkVal("alloc.rec", bpIf.RecoverPCE, 32'h80);
    checkVal("alloc.rbw", {31'd0, bpIf.PredTakenF}, 32'd0);
    @(posedge clk);
    #1;
    bpIf.UpdateE = 1'b0;
    lookup(32'h100, 1'b1, 32'h80, "alloc");

    // Counter walk from 2: NT,NT,NT -> 1,0,0; T -> 1; T -> 2.
    train(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h104, "nt1");
    lookup(32'h100, 1'b0, 32'h104, "ctr1");
    train(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, "nt2");
    train(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "nt3");
    lookup(32'h100, 1'b0, 32'h104, "ctr0");
    train(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t1");
    lookup(32'h100, 1'b0, 32'h104, "ctrUp1");
    train(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t2");
    lookup(32'h100, 1'b1, 32'h80, "ctrUp2");
    // Correct prediction, then right direction with wrong target.
    train(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80, "good");
    train(32'h100, 1'b1, 32'hA0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'hA0, "badTgt");
    lookup(32'h100, 1'b1, 32'hA0, "newTgt");

    // Alias: 0x500 shares index 0 with 0x100 but carries a different tag.
    lookup(32'h500, 1'b0, 32'h504, "aliasMiss");
    train(32'h500, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "alias");
    lookup(32'h500, 1'b1, 32'h40, "aliasHit");
    lookup(32'h100, 1'b0, 32'h104, "evicted");

    // Stalled update: held 3 edges, then exactly one accepted edge.
`ifdef BP_STATS_EN
    statBase = bpIf.StatBranches;
`endif
    @(negedge clk);
    bpIf.PCF   = 32'h100;
    bpIf.stall = 1'b1;
    setUpdate(32'h100, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
    #1;
    checkVal("stall.mis", {31'd0, bpIf.MispredictE}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkVal("stall.frozen", {31'd0, bpIf.PredTakenF}, 32'd0);
    @(negedge clk);
    bpIf.stall = 1'b0;
    @(posedge clk);
    #1;
    bpIf.UpdateE = 1'b0;
    lookup(32'h100, 1'b1, 32'h60, "stallAlloc");
    // Allocation gives ctr=2; one NT leaves 1 (a double-train would give 3 -> 2).
    train(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, "stallNt");
    lookup(32'h100, 1'b0, 32'h104, "stallOnce");
`ifdef BP_STATS_EN
    checkVal("statBranches", bpIf.StatBranches, statBase + 32'd2);
`endif

    // JAL forces ctr=3; one NT keeps it taken; JALR retargets.
    train(32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, "jal");
    lookup(32'h200, 1'b1, 32'h300, "jalHit");
    train(32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h204, "jalNt");
    lookup(32'h200, 1'b1, 32'h300, "jalStrong");
    train(32'h200, 1'b1, 32'h340, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h340, "jalr");
    lookup(32'h200, 1'b1, 32'h340, "jalrHit");

    // Asynchronous reset between edges drops the prediction immediately.
    @(negedge clk);
    bpIf.PCF = 32'h200;
    #2;
    rst = 1'b0;
    #1;
    checkVal("asyncRst.taken",  {31'd0, bpIf.PredTakenF}, 32'd0);
    checkVal("asyncRst.target", bpIf.PredTargetF, 32'h204);
`ifdef BP_STATS_EN
    checkVal("asyncRst.stat", bpIf.StatBranches, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    lookup(32'h500, 1'b0, 32'h504, "asyncRstAlias");

    $display("End of test - %0d assertions evaluated, %0d failures", asrtCnt, failCnt);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline. Replaces the fixed "predict not-taken, flush on taken" behaviour.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up combinationally with PCF in fetch; trained by branches and jumps resolved in execute.
- Also generates the execute-stage mispredict flag and the recovery PC consumed by the hazard unit and program counter.

Parameters:
- WIDTH, 32, address/data width.
- ENTRIES, 64, BTB entries; power of two, ≥2. INDEX_BITS = $clog2(ENTRIES).
- TAG_WIDTH, 10, tag bits taken from PC[INDEX_BITS+2 +: TAG_WIDTH].
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- stall  input  1  pipeline stall; blocks training.
- PCF  input  WIDTH  fetch PC.
- PredTakenF  output  1  predicted taken.
- PredTargetF  output  WIDTH  predicted next PC.
- UpdateE  input  1  execute holds a resolved branch/jump.
- UpdatePCE  input  WIDTH  PC of that instruction.
- UpdateTakenE  input  1  actual outcome.
- UpdateTargetE  input  WIDTH  actual taken target.
- UpdateUncondE  input  1  JAL (unconditional, fixed target).
- PredTakenE  input  1  prediction carried down the pipe.
- PredTargetE  input  WIDTH  predicted target carried down the pipe.
- MispredictE  output  1  flush request.
- RecoverPCE  output  WIDTH  correct next PC.

Behaviour:
- Index idx = PC[INDEX_BITS+1:2]. Tag = PC[INDEX_BITS+2 +: TAG_WIDTH]. Per entry: valid, tag, target[WIDTH], ctr[2].
- Lookup (combinational):
  - hit = valid[idx] && tag match.
  - PredTakenF = hit && ctr[1].
  - PredTargetF = target when PredTakenF, else PCF+4 (mod 2^WIDTH).
- Training occurs on the rising edge when UpdateE && !stall. With stall=1 nothing changes, so a frozen execute stage cannot retrain twice.
- On a miss (invalid or tag mismatch):
  - Taken: allocate or overwrite. valid=1, tag, target=UpdateTargetE, ctr = UpdateUncondE ? 2'b11 : 2'b10.
  - Not taken: no allocation, no change.
- On a hit:
  - Taken: ctr saturating +1 (max 3); target overwritten with UpdateTargetE (covers JALR).
  - Not taken: ctr saturating -1 (min 0).
  - UpdateUncondE forces ctr=2'b11.
- Lookup and update to the same entry in the same cycle: lookup returns pre-edge contents (read-before-write, no bypass). The new state is visible from the next cycle.
- Mispredict and recovery (combinational):
  - MispredictE = UpdateE && (PredTakenE != UpdateTakenE || (UpdateTakenE && PredTargetE != UpdateTargetE)).
  - RecoverPCE = UpdateTakenE ? UpdateTargetE : UpdatePCE+4.
  - Neither output is masked by stall.
- Reset (rst=0, async, any time including mid-update):
  - All valid=0, ctr=CTR_INIT, target=0, counters of the optional feature=0.
  - Outputs immediately: PredTakenF=0, PredTargetF=PCF+4.
  - MispredictE and RecoverPCE follow their inputs.
  - First training edge accepted is the first rising edge after rst returns to 1.
- Latency: prediction 0 cycles; training visible 1 cycle after the edge.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - Extra output StatBranches[31:0] increments on every accepted update (UpdateE && !stall).
  - Extra output StatMispredicts[31:0] increments when an accepted update also has MispredictE=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset, PCF=0x100 → PredTakenF=0, PredTargetF=0x104. Pulse rst=0 between clock edges after training → PredTakenF drops to 0 without a clock edge.
- Update PC=0x100, taken, target=0x80, PredTakenE=0 → MispredictE=1, RecoverPCE=0x80. Next cycle PCF=0x100 → PredTakenF=1, PredTargetF=0x80.
- Counter walk at 0x100, starting from ctr=2:
  - not-taken, not-taken, not-taken → ctr 1,0,0 (saturates); PredTakenF=0.
  - taken → ctr 1; PredTakenF still 0.
  - taken → ctr 2; PredTakenF=1.
- Alias at ENTRIES=64: PCF=0x500 (idx 0, tag 5 vs tag 1 for 0x100) → miss, PredTargetF=0x504. Taken update at 0x500, target 0x40 → entry replaced; 0x100 now misses.
- Update held with stall=1 for 3 cycles, then stall=0 → exactly one training step. With BP_STATS_EN, StatBranches increments by 1.
- JAL update at 0x200 with UpdateUncondE=1, target 0x300 → ctr=3. A single not-taken update leaves PredTakenF=1. A JALR taken at the same PC with target 0x340 → PredTargetF=0x340.
